ps2_key_decoder: RTL and testbench

//  Sits between the PS/2 byte receiver (rx_data/read_data) and the ASCII lookup RAM.

---
 rtl/ps2_key_decoder_pkg.sv | 24 ++
 rtl/ps2_key_decoder_fifo.sv | 60 ++++++
 rtl/ps2_key_decoder.sv | 94 +++++++++
 tb/tb_ps2_key_decoder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared scan-code constants, FSM encodings and the queued key-event layout
// for the PS/2 key decoder.
package ps2_key_decoder_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;

    localparam int CODE_W  = 7;
    localparam int FLAG_W  = 2;
    localparam int ENTRY_W = CODE_W + FLAG_W;

    // bit 0 = E0 seen, bit 1 = F0 seen
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_EXT     = 2'b01;
    localparam logic [1:0] ST_BRK     = 2'b10;
    localparam logic [1:0] ST_EXT_BRK = 2'b11;

    typedef struct packed {
        logic              ext;
        logic              rel;
        logic [CODE_W-1:0] code;
    } key_event_t;

endpackage

// File: rtl/ps2_key_decoder_fifo.sv
// Registered show-ahead FIFO; push on a full queue is accepted only when a
// pop frees the head slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 scan-code bytes (E0/F0 prefixed) into make/break key events,
// filters typematic repeats and queues the events for the CPU side.
module ps2_key_decoder #(
    parameter int DEPTH           = 8,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   read_data,
    input  logic                   pop,
    output logic                   key_valid,
    output logic [6:0]             key_data,
    output logic                   key_release,
    output logic                   key_extended,
    output logic [6:0]             held_key,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    import ps2_key_decoder_pkg::*;

    logic [1:0]        state_q, state_d;
    logic [CODE_W-1:0] held_q, held_d;
    logic              ovf_q, ovf_d;
    logic              push_req;
    key_event_t        push_ev;
    key_event_t        head;
    logic              fifo_empty, fifo_full;

    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        push_req = 1'b0;
        push_ev  = '0;
        if (read_data) begin
            if (rx_data == SC_EXT) begin
                state_d = ST_EXT;
            end else if (rx_data == SC_BREAK) begin
                state_d = {1'b1, state_q[0]};
            end else if (rx_data[7]) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_IDLE;
                push_ev = '{ext: state_q[0], rel: state_q[1],
                            code: rx_data[6:0]};
                if (state_q[1]) begin
                    push_req = 1'b1;
                    if (rx_data[6:0] == held_q) held_d = '0;
                end else if (!(SUPPRESS_REPEAT && rx_data[6:0] == held_q)) begin
                    push_req = 1'b1;
                    held_d   = rx_data[6:0];
                end
            end
        end
        // a full queue only drops the event when no pop frees a slot
        ovf_d = ovf_q || (push_req && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            held_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .din   (push_ev),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign key_valid    = !fifo_empty;
    assign key_data     = head.code;
    assign key_release  = head.rel;
    assign key_extended = head.ext;
    assign held_key     = held_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: vector table plus hand-written
// sequences for pop ordering, overflow and reset corner cases.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       read_data;
    logic       pop;

    logic       kv, kr, ke, ov;
    logic [6:0] kd, hk;
    logic [3:0] cnt;

    logic       kv0, kr0, ke0, ov0;
    logic [6:0] kd0, hk0;
    logic [3:0] cnt0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ps2_key_decoder #(.DEPTH(8), .SUPPRESS_REPEAT(1'b1)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .read_data(read_data),
        .pop(pop), .key_valid(kv), .key_data(kd), .key_release(kr),
        .key_extended(ke), .held_key(hk), .fifo_count(cnt), .overflow(ov)
    );

    ps2_key_decoder #(.DEPTH(8), .SUPPRESS_REPEAT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .read_data(read_data),
        .pop(pop), .key_valid(kv0), .key_data(kd0), .key_release(kr0),
        .key_extended(ke0), .held_key(hk0), .fifo_count(cnt0), .overflow(ov0)
    );

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         n;
        int         cnt;
        int         cnt0;
        logic [6:0] code;
        logic       rel;
        logic       ext;
        logic [6:0] held;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic p);
        rx_data   = b;
        read_data = 1'b1;
        pop       = p;
        @(negedge clk);
        read_data = 1'b0;
        pop       = 1'b0;
        rx_data   = 8'h00;
    endtask

    task automatic pop_once();
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        read_data = 1'b0;
        pop       = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic vec_t mkv(input logic [7:0] b0, b1, b2, input int n,
                                 input int c, c0, input logic [6:0] code,
                                 input logic rel, ext, input logic [6:0] held);
        vec_t v;
        v.b0 = b0; v.b1 = b1; v.b2 = b2; v.n = n;
        v.cnt = c; v.cnt0 = c0; v.code = code;
        v.rel = rel; v.ext = ext; v.held = held;
        return v;
    endfunction

    initial begin
        logic [7:0] bs [3];
        logic [7:0] k;

        vecs[0]  = mkv(8'h1C, 8'h00, 8'h00, 1, 1, 1, 7'h1C, 0, 0, 7'h1C);
        vecs[1]  = mkv(8'hE0, 8'h75, 8'h00, 2, 1, 1, 7'h75, 0, 1, 7'h75);
        vecs[2]  = mkv(8'hF0, 8'h1C, 8'h00, 2, 1, 1, 7'h1C, 1, 0, 7'h00);
        vecs[3]  = mkv(8'hE0, 8'hF0, 8'h75, 3, 1, 1, 7'h75, 1, 1, 7'h00);
        vecs[4]  = mkv(8'hAA, 8'h00, 8'h00, 1, 0, 0, 7'h00, 0, 0, 7'h00);
        vecs[5]  = mkv(8'hAA, 8'hFA, 8'h00, 2, 0, 0, 7'h00, 0, 0, 7'h00);
        vecs[6]  = mkv(8'h1C, 8'h1C, 8'h1C, 3, 1, 3, 7'h1C, 0, 0, 7'h1C);
        vecs[7]  = mkv(8'hE0, 8'hE0, 8'h12, 3, 1, 1, 7'h12, 0, 1, 7'h12);
        vecs[8]  = mkv(8'hF0, 8'hF0, 8'h1C, 3, 1, 1, 7'h1C, 1, 0, 7'h00);
        vecs[9]  = mkv(8'hE0, 8'hAA, 8'h1C, 3, 1, 1, 7'h1C, 0, 0, 7'h1C);
        vecs[10] = mkv(8'hF0, 8'hE0, 8'h75, 3, 1, 1, 7'h75, 0, 1, 7'h75);
        vecs[11] = mkv(8'hE0, 8'hF0, 8'hE0, 3, 0, 0, 7'h00, 0, 0, 7'h00);

        reset = 1'b1; rx_data = 8'h00; read_data = 1'b0; pop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_valid", kv, 0);
        chk("rst_data", kd, 0);
        chk("rst_rel", kr, 0);
        chk("rst_ext", ke, 0);
        chk("rst_held", hk, 0);
        chk("rst_count", cnt, 0);
        chk("rst_ovf", ov, 0);

        foreach (vecs[i]) begin
            do_reset();
            bs[0] = vecs[i].b0; bs[1] = vecs[i].b1; bs[2] = vecs[i].b2;
            for (int j = 0; j < vecs[i].n; j++) send(bs[j], 1'b0);
            chk($sformatf("v%0d_count", i), cnt, vecs[i].cnt);
            chk($sformatf("v%0d_count_norep", i), cnt0, vecs[i].cnt0);
            chk($sformatf("v%0d_valid", i), kv, vecs[i].cnt != 0);
            chk($sformatf("v%0d_code", i), kd, vecs[i].code);
            chk($sformatf("v%0d_rel", i), kr, vecs[i].rel);
            chk($sformatf("v%0d_ext", i), ke, vecs[i].ext);
            chk($sformatf("v%0d_held", i), hk, vecs[i].held);
            chk($sformatf("v%0d_ovf", i), ov, 0);
        end

        // make followed by break, popped in order
        do_reset();
        send(8'h1C, 1'b0);
        chk("mb_valid1", kv, 1);
        chk("mb_held1", hk, 7'h1C);
        send(8'hF0, 1'b0);
        send(8'h1C, 1'b0);
        chk("mb_count", cnt, 2);
        chk("mb_held2", hk, 0);
        chk("mb_head_rel", kr, 0);
        pop_once();
        chk("mb_second_rel", kr, 1);
        chk("mb_second_code", kd, 7'h1C);
        pop_once();
        chk("mb_empty", kv, 0);

        // extended make then extended break
        do_reset();
        send(8'hE0, 1'b0); send(8'h75, 1'b0);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
        chk("ext_count", cnt, 2);
        chk("ext_h1", {ke, kr, kd}, {1'b1, 1'b0, 7'h75});
        pop_once();
        chk("ext_h2", {ke, kr, kd}, {1'b1, 1'b1, 7'h75});
        chk("ext_held", hk, 0);

        // fill, push+pop at full, then overflow
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            k = 8'(i);
            send(k, 1'b0);
        end
        chk("full_count", cnt, 8);
        chk("full_ovf", ov, 0);
        send(8'h09, 1'b1);
        chk("pp_count", cnt, 8);
        chk("pp_ovf", ov, 0);
        chk("pp_head", kd, 7'h02);
        send(8'h0A, 1'b0);
        chk("of_count", cnt, 8);
        chk("of_ovf", ov, 1);
        chk("of_held", hk, 7'h0A);
        for (int i = 2; i <= 9; i++) begin
            chk($sformatf("drain_%0d", i), kd, i);
            pop_once();
        end
        chk("drain_empty", kv, 0);
        chk("drain_ovf_sticky", ov, 1);

        // reset wins over a same-cycle byte and pop
        send(8'h33, 1'b0);
        reset = 1'b1; rx_data = 8'h1C; read_data = 1'b1; pop = 1'b1;
        @(negedge clk);
        reset = 1'b0; read_data = 1'b0; pop = 1'b0;
        chk("rw_count", cnt, 0);
        chk("rw_held", hk, 0);
        chk("rw_ovf", ov, 0);

        // reset discards a pending F0
        send(8'hF0, 1'b0);
        do_reset();
        send(8'h1C, 1'b0);
        chk("rs_valid", kv, 1);
        chk("rs_rel", kr, 0);
        chk("rs_code", kd, 7'h1C);
        chk("rs_ovf", ov, 0);
        pop_once();
        chk("rs_count1", cnt, 0);
        pop_once();
        chk("rs_count2", cnt, 0);
        chk("rs_valid2", kv, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
